svreal_mac_pipe: RTL

SVREAL_MAC_PIPE -- requirements
Module: svreal_mac_pipe

---
 rtl/svreal_mac_pipe.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/svreal_mac_pipe.sv
// svreal_mac_pipe
// ---------------------------------------------------------------------------
// Pipelined fixed-point multiply-accumulate for "svreal" style signed values.
// Every accepted beat contributes a_value*b_value to a running accumulator.
// The accumulation closes either on a beat flagged in_last or when max_count
// terms have been summed, and the finished sum is presented on out_*.
//
// Real-number interpretation:
//   a real   = a_value   * 2^a_exponent
//   b real   = b_value   * 2^b_exponent
//   out real = out_value * 2^acc_exponent
//
// Pipeline: stage 1 registers the full-width product, stage 2 aligns it to
// the accumulator exponent, adds it and, on close, loads the output registers.
// A stalled output (out_valid && !out_ready) freezes the whole pipe.
//
// Ports:
//   clk, rst            - rising-edge clock, synchronous active-high reset
//   in_valid/in_ready   - input handshake; in_ready is combinational
//   a_value, b_value    - signed fixed-point operands
//   in_last             - beat is the final term of this accumulation
//   out_valid/out_ready - output handshake
//   out_value           - signed accumulated sum at acc_exponent
//   out_count           - number of terms in the result
//   out_sat             - saturation/wrap happened during this accumulation
//   out_overrun         - accumulation closed by max_count, not by in_last
// ---------------------------------------------------------------------------
module svreal_mac_pipe #(
    parameter int a_width      = 16,
    parameter int a_exponent   = -8,
    parameter int b_width      = 16,
    parameter int b_exponent   = -8,
    parameter int acc_width    = 32,
    parameter int acc_exponent = -16,
    parameter int sat_en       = 1,
    parameter int max_count    = 16
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic signed [a_width-1:0]          a_value,
    input  logic signed [b_width-1:0]          b_value,
    input  logic                               in_last,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic signed [acc_width-1:0]        out_value,
    output logic [$clog2(max_count+1)-1:0]     out_count,
    output logic                               out_sat,
    output logic                               out_overrun
);

    localparam int prod_width   = a_width + b_width;
    localparam int lshift       = a_exponent + b_exponent - acc_exponent;
    localparam int lshift_left  = (lshift > 0) ? lshift : 0;
    localparam int lshift_right = (lshift < 0) ? -lshift : 0;
    // Wide enough to hold the left-shifted product and any accumulator value,
    // so the fit check below never loses information.
    localparam int ext_width    = prod_width + lshift_left + acc_width;
    localparam int cnt_width    = $clog2(max_count + 1);

    localparam logic signed [acc_width-1:0] acc_max = {1'b0, {(acc_width-1){1'b1}}};
    localparam logic signed [acc_width-1:0] acc_min = {1'b1, {(acc_width-1){1'b0}}};
    localparam logic [cnt_width-1:0]        max_cnt = cnt_width'(max_count);

    logic                          advance;
    logic signed [prod_width-1:0]  product;

    logic                          s1_valid;
    logic                          s1_last;
    logic signed [prod_width-1:0]  s1_prod;

    logic signed [acc_width-1:0]   acc;
    logic [cnt_width-1:0]          count;
    logic                          sat;

    logic signed [ext_width-1:0]   aligned_wide;
    logic                          align_fits;
    logic signed [acc_width-1:0]   aligned;
    logic [acc_width:0]            sum_wide;
    logic                          sum_ovf;
    logic signed [acc_width-1:0]   acc_next;
    logic [cnt_width-1:0]          count_next;
    logic                          sat_next;
    logic                          hit_max;
    logic                          close;

    // The whole pipe moves together: it only stalls when a finished result is
    // waiting and nobody is taking it. Input acceptance follows directly.
    always_comb begin
        advance  = !(out_valid && !out_ready);
        in_ready = advance;
        product  = prod_width'(a_value) * prod_width'(b_value);
    end

    // Stage-2 datapath. The product is first shifted onto the accumulator's
    // binary point (an arithmetic right shift gives floor rounding), then
    // range-checked against acc_width before being added. The add is done one
    // bit wider so overflow is visible as a disagreement of the two top bits.
    // Either overflow marks the accumulation as saturated (or wrapped).
    always_comb begin
        aligned_wide = (ext_width'(s1_prod) <<< lshift_left) >>> lshift_right;
        align_fits   = (aligned_wide == ext_width'(signed'(aligned_wide[acc_width-1:0])));

        aligned = aligned_wide[acc_width-1:0];
        if (!align_fits && (sat_en != 0)) begin
            aligned = aligned_wide[ext_width-1] ? acc_min : acc_max;
        end

        sum_wide = {acc[acc_width-1], acc} + {aligned[acc_width-1], aligned};
        sum_ovf  = (sum_wide[acc_width] != sum_wide[acc_width-1]);

        acc_next = sum_wide[acc_width-1:0];
        if (sum_ovf && (sat_en != 0)) begin
            acc_next = sum_wide[acc_width] ? acc_min : acc_max;
        end

        sat_next   = sat || !align_fits || sum_ovf;
        count_next = count + cnt_width'(1);
        hit_max    = (count_next == max_cnt);
        close      = s1_valid && (s1_last || hit_max);
    end

    // All state registers. Reset wins over everything and throws away any
    // partial sum or pending result. When the pipe advances, stage 1 captures
    // the new beat (or goes empty), stage 2 folds the stage-1 term into the
    // accumulator, and a closing term hands the final values to the outputs
    // while restarting the accumulator from zero on the same edge. out_valid
    // follows close on every advance, which both consumes the old result and
    // presents a new one when they coincide.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid    <= 1'b0;
            s1_last     <= 1'b0;
            s1_prod     <= '0;
            acc         <= '0;
            count       <= '0;
            sat         <= 1'b0;
            out_valid   <= 1'b0;
            out_value   <= '0;
            out_count   <= '0;
            out_sat     <= 1'b0;
            out_overrun <= 1'b0;
        end else if (advance) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_prod <= product;
                s1_last <= in_last;
            end

            if (s1_valid) begin
                if (close) begin
                    out_value   <= acc_next;
                    out_count   <= count_next;
                    out_sat     <= sat_next;
                    out_overrun <= hit_max && !s1_last;
                    acc         <= '0;
                    count       <= '0;
                    sat         <= 1'b0;
                end else begin
                    acc   <= acc_next;
                    count <= count_next;
                    sat   <= sat_next;
                end
            end

            out_valid <= close;
        end
    end

endmodule
